csa_acc_tree: RTL

CSA_ACC_TREE -- requirements
Module: csa_acc_tree

---
 rtl/csa_acc_tree_if.sv | 26 ++
 rtl/csa_acc_tree.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/csa_acc_tree_if.sv
// Beat/result handshake bundle for csa_acc_tree: operand beats in, signed group results out.
interface csa_acc_tree_if #(
    parameter int unsigned N     = 8,
    parameter int unsigned W     = 8,
    parameter int unsigned OUT_W = 24
);
    logic [N*W-1:0]   in_data;
    logic             in_valid;
    logic             in_first;
    logic             in_last;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, in_first, in_last, out_ready,
        input  in_ready, out_data, out_ovf, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_first, in_last, out_ready,
        output in_ready, out_data, out_ovf, out_valid
    );
endinterface

// File: rtl/csa_acc_tree.sv
// Carry-save reduction of N signed operands per beat, accumulated across a first..last group.
// Pipeline: beat capture -> CSA tree to sum/carry -> final add + accumulate + overflow tracking.
module csa_acc_tree #(
    parameter int unsigned N     = 8,
    parameter int unsigned W     = 8,
    parameter int unsigned OUT_W = 24
) (
    input  logic           clk,
    input  logic           reset_n,
    csa_acc_tree_if.slave  bus
);
    // Enough 3:2 levels to bring 16 vectors down to 2 (16-11-8-6-4-3-2).
    localparam int unsigned MAX_LVL = 6;

    if (OUT_W < W + $clog2(N)) begin : g_width_chk
        $error("csa_acc_tree: OUT_W too narrow for N operands of W bits");
    end
    if (N < 4 || N > 16) begin : g_n_chk
        $error("csa_acc_tree: N must be within 4..16");
    end

    logic [N*W-1:0]   s0_data_q, s0_data_d;
    logic             s0_valid_q, s0_valid_d, s0_first_q, s0_first_d, s0_last_q, s0_last_d;
    logic [OUT_W-1:0] s1_sum_q, s1_sum_d, s1_carry_q, s1_carry_d;
    logic             s1_valid_q, s1_valid_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
    logic [OUT_W-1:0] acc_q, acc_d, out_data_q, out_data_d;
    logic             ovf_acc_q, ovf_acc_d, out_ovf_q, out_ovf_d, out_valid_q, out_valid_d;

    logic             stall_c;
    logic [OUT_W-1:0] red [N];
    logic [OUT_W-1:0] nxt [N];
    logic [OUT_W-1:0] ca, cb, cc;
    int unsigned      cnt, grp, rem;
    logic [OUT_W-1:0] csa_sum_c, csa_carry_c;
    logic [OUT_W-1:0] partial_c, base_c, total_c;
    logic             ovf_evt_c, grp_ovf_c;

    assign stall_c      = out_valid_q & ~bus.out_ready;
    assign bus.in_ready = ~stall_c;
    assign bus.out_data = out_data_q;
    assign bus.out_ovf  = out_ovf_q;
    assign bus.out_valid = out_valid_q;

    // Wallace-style reduction: each level compresses triples into sum + shifted majority.
    always_comb begin
        ca  = '0;
        cb  = '0;
        cc  = '0;
        grp = 0;
        rem = 0;
        cnt = N;
        for (int unsigned i = 0; i < N; i++) begin
            red[i] = OUT_W'($signed(s0_data_q[i*W +: W]));
            nxt[i] = '0;
        end
        for (int unsigned l = 0; l < MAX_LVL; l++) begin
            if (cnt > 2) begin
                grp = cnt / 3;
                rem = cnt - 3 * grp;
                for (int unsigned k = 0; k < N; k++) begin
                    nxt[k] = '0;
                end
                for (int unsigned k = 0; k < N / 3; k++) begin
                    if (k < grp) begin
                        ca = red[3*k];
                        cb = red[3*k+1];
                        cc = red[3*k+2];
                        nxt[2*k]   = ca ^ cb ^ cc;
                        nxt[2*k+1] = ((ca & cb) | (ca & cc) | (cb & cc)) << 1;
                    end
                end
                for (int unsigned r = 0; r < 2; r++) begin
                    if (r < rem) begin
                        nxt[2*grp+r] = red[3*grp+r];
                    end
                end
                for (int unsigned k = 0; k < N; k++) begin
                    red[k] = nxt[k];
                end
                cnt = 2 * grp + rem;
            end
        end
        csa_sum_c   = red[0];
        csa_carry_c = red[1];
    end

    // Final carry-propagate add and group accumulation; overflow is a same-sign add flipping sign.
    always_comb begin
        partial_c = s1_sum_q + s1_carry_q;
        base_c    = s1_first_q ? '0 : acc_q;
        total_c   = base_c + partial_c;
        ovf_evt_c = (base_c[OUT_W-1] == partial_c[OUT_W-1]) && (total_c[OUT_W-1] != base_c[OUT_W-1]);
        grp_ovf_c = s1_first_q ? ovf_evt_c : (ovf_acc_q | ovf_evt_c);
    end

    // Everything holds under stall. acc is zero out of reset, so the first post-reset beat
    // accumulates from zero whether or not it carries in_first.
    always_comb begin
        s0_data_d   = s0_data_q;
        s0_valid_d  = s0_valid_q;
        s0_first_d  = s0_first_q;
        s0_last_d   = s0_last_q;
        s1_sum_d    = s1_sum_q;
        s1_carry_d  = s1_carry_q;
        s1_valid_d  = s1_valid_q;
        s1_first_d  = s1_first_q;
        s1_last_d   = s1_last_q;
        acc_d       = acc_q;
        ovf_acc_d   = ovf_acc_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;
        if (!stall_c) begin
            s0_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s0_data_d  = bus.in_data;
                s0_first_d = bus.in_first;
                s0_last_d  = bus.in_last;
            end
            s1_valid_d = s0_valid_q;
            if (s0_valid_q) begin
                s1_sum_d   = csa_sum_c;
                s1_carry_d = csa_carry_c;
                s1_first_d = s0_first_q;
                s1_last_d  = s0_last_q;
            end
            out_valid_d = s1_valid_q & s1_last_q;
            if (s1_valid_q) begin
                if (s1_last_q) begin
                    out_data_d = total_c;
                    out_ovf_d  = grp_ovf_c;
                    acc_d      = '0;
                    ovf_acc_d  = 1'b0;
                end else begin
                    acc_d      = total_c;
                    ovf_acc_d  = grp_ovf_c;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_data_q   <= '0;
            s0_valid_q  <= 1'b0;
            s0_first_q  <= 1'b0;
            s0_last_q   <= 1'b0;
            s1_sum_q    <= '0;
            s1_carry_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            acc_q       <= '0;
            ovf_acc_q   <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s0_data_q   <= s0_data_d;
            s0_valid_q  <= s0_valid_d;
            s0_first_q  <= s0_first_d;
            s0_last_q   <= s0_last_d;
            s1_sum_q    <= s1_sum_d;
            s1_carry_q  <= s1_carry_d;
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            acc_q       <= acc_d;
            ovf_acc_q   <= ovf_acc_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule
